// File: rtl/prom_coherente_frame_reader.sv
// prom_coherente_frame_reader
// Captures one complete M-point averaged frame from the coherent averager's
// output stream into on-chip RAM on request. The host then reads the frame
// through a 1-cycle-latency port that applies an arithmetic right shift.
//
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   enable              block enable; low aborts any capture and resyncs idx
//   ptos_x_ciclo        M, points per frame (same value the averager uses)
//   shift_div           arithmetic right shift applied on read, sampled with rd_en
//   arm                 pulse: capture the next full frame
//   release_req         pulse: host finished reading, return to idle
//                       (named release_req because `release` is a reserved word)
//   data_in_valid/_in   averaged sample stream, signed
//   rd_en, rd_addr      read strobe and point index
//   rd_data(_valid)     buf[rd_addr] >>> shift_div, one cycle after rd_en
//   busy                armed or capturing
//   frame_ready         a complete frame is held for readout
//   cfg_err             combinational: M == 0 or M > BUF_TAM
//   frames_captured     completed captures, wraps at 2^16
module prom_coherente_frame_reader #(
  parameter int unsigned BUF_TAM = 2048,
  parameter int unsigned ADDR_W  = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [15:0]         ptos_x_ciclo,
  input  logic [4:0]          shift_div,
  input  logic                arm,
  input  logic                release_req,
  input  logic                data_in_valid,
  input  logic signed [31:0]  data_in,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic signed [31:0]  rd_data,
  output logic                rd_data_valid,
  output logic                busy,
  output logic                frame_ready,
  output logic                cfg_err,
  output logic [15:0]         frames_captured
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_READY
  } state_t;

  state_t state_q, state_d;

  logic signed [31:0] mem [BUF_TAM];

  logic [15:0]        idx_q;
  logic [15:0]        idx_plus_c;
  logic               idx_last_c;
  logic               wr_en_c;
  logic               done_c;
  logic               rd_fire_c;
  logic signed [31:0] rd_word_c;

  // Frame length sanity, visible to the host without delay.
  assign cfg_err = (ptos_x_ciclo == 16'd0) || (32'(ptos_x_ciclo) > BUF_TAM);

  assign idx_plus_c = idx_q + 16'd1;
  assign idx_last_c = (idx_q == ptos_x_ciclo - 16'd1);

  // Out-of-frame addresses read as zero rather than stale RAM contents.
  assign rd_fire_c = enable && (state_q == ST_READY) && rd_en;
  assign rd_word_c = (16'(rd_addr) >= ptos_x_ciclo) ? 32'sd0
                                                    : 32'(mem[rd_addr] >>> shift_div);

  // Next-state and write decision.
  always_comb begin
    state_d = state_q;
    wr_en_c = 1'b0;
    done_c  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm && !cfg_err) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (cfg_err) begin
            state_d = ST_IDLE;
          end else if (data_in_valid && (idx_q == 16'd0)) begin
            // A one-point frame completes on its first sample.
            wr_en_c = 1'b1;
            if (idx_last_c) begin
              done_c  = 1'b1;
              state_d = ST_READY;
            end else begin
              state_d = ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (cfg_err) begin
            state_d = ST_IDLE;
          end else if (data_in_valid) begin
            wr_en_c = 1'b1;
            if (idx_last_c) begin
              done_c  = 1'b1;
              state_d = ST_READY;
            end
          end
        end
        ST_READY: begin
          if (arm && !cfg_err) state_d = ST_ARMED;
          else if (release_req) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, flags, point index, capture counter and read port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      idx_q           <= 16'd0;
      busy            <= 1'b0;
      frame_ready     <= 1'b0;
      frames_captured <= 16'd0;
      rd_data_valid   <= 1'b0;
      rd_data         <= 32'sd0;
    end else begin
      state_q     <= state_d;
      busy        <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
      frame_ready <= (state_d == ST_READY);
      if (!enable) begin
        idx_q <= 16'd0;
      end else if (data_in_valid) begin
        idx_q <= (idx_plus_c >= ptos_x_ciclo) ? 16'd0 : idx_plus_c;
      end
      if (done_c) frames_captured <= frames_captured + 16'd1;
      rd_data_valid <= rd_fire_c;
      if (rd_fire_c) rd_data <= rd_word_c;
    end
  end

  // Frame buffer; contents survive reset and enable drops.
  always_ff @(posedge clk) begin
    if (wr_en_c && reset) mem[idx_q[ADDR_W-1:0]] <= data_in;
  end

endmodule
